// File: rtl/triumph_dmem_arbiter.sv
//-----------------------------------------------------------------------------
// triumph_dmem_arbiter
//
// Shares one single-port, synchronous-read data memory between the core's
// load/store unit and an external requester (loader / debug port).
//
// The core normally has priority. An external request that keeps losing to
// the core is counted, and after MAX_EXT_WAIT consecutive denials it is forced
// through for one cycle while the core is stalled. Read responses come back
// one cycle after the access, and they are steered to whichever side issued
// the read.
//
// Parameters
//   MAX_EXT_WAIT  denied cycles tolerated before an external request is
//                 forced through (1..15)
//
// Ports
//   clk_i          clock, rising edge
//   rstn_i         asynchronous active-low reset
//   core_req_i     core access request
//   core_we_i      core write enable (1 = store)
//   core_addr_i    core byte address
//   core_wdata_i   core store data
//   core_rdata_o   load data to the core (0 unless a core read is returning)
//   core_stall_o   core request not served this cycle
//   ext_req_i      external access request
//   ext_we_i       external write enable
//   ext_addr_i     external byte address
//   ext_wdata_i    external write data
//   ext_gnt_o      external request accepted this cycle
//   ext_rvalid_o   external read data valid
//   ext_rdata_o    external read data (0 unless ext_rvalid_o)
//   mem_addr_o     memory address
//   mem_we_o       memory write enable
//   mem_wdata_o    memory write data
//   mem_rdata_i    memory read data, one cycle after the address
//-----------------------------------------------------------------------------
module triumph_dmem_arbiter #(
    parameter int unsigned MAX_EXT_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_stall_o,

    input  logic        ext_req_i,
    input  logic        ext_we_i,
    input  logic [31:0] ext_addr_i,
    input  logic [31:0] ext_wdata_i,
    output logic        ext_gnt_o,
    output logic        ext_rvalid_o,
    output logic [31:0] ext_rdata_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_e;

    localparam logic [3:0] MaxWait = 4'(MAX_EXT_WAIT);

    owner_e     owner;
    logic       owner_we;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    owner_e     rsp_q, rsp_d;

    // Owner selection: the external side wins outright when the core is idle,
    // and wins over a requesting core only once it has waited MaxWait cycles.
    always_comb begin
        owner = OWN_NONE;
        if (ext_req_i && (!core_req_i || (starve_cnt_q == MaxWait))) begin
            owner = OWN_EXT;
        end else if (core_req_i) begin
            owner = OWN_CORE;
        end
    end

    // Memory port mux; an idle cycle drives zeros so nothing stale leaks out.
    always_comb begin
        mem_addr_o   = 32'd0;
        mem_wdata_o  = 32'd0;
        owner_we     = 1'b0;
        ext_gnt_o    = 1'b0;
        core_stall_o = 1'b0;
        unique case (owner)
            OWN_CORE: begin
                mem_addr_o  = core_addr_i;
                mem_wdata_o = core_wdata_i;
                owner_we    = core_we_i;
            end
            OWN_EXT: begin
                mem_addr_o   = ext_addr_i;
                mem_wdata_o  = ext_wdata_i;
                owner_we     = ext_we_i;
                ext_gnt_o    = 1'b1;
                core_stall_o = core_req_i;
            end
            default: ;
        endcase
    end

    assign mem_we_o = owner_we;

    // Starvation counter: counts consecutive denials of a live external
    // request. Any grant or any gap in the request restarts it, so a
    // requester that gives up gets no credit for the time already waited.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ext_req_i || (owner == OWN_EXT)) begin
            starve_cnt_d = 4'd0;
        end else if ((owner == OWN_CORE) && (starve_cnt_q < MaxWait)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Only reads produce a response next cycle; writes and idle cycles do not.
    always_comb begin
        rsp_d = OWN_NONE;
        if ((owner != OWN_NONE) && !owner_we) begin
            rsp_d = owner;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            starve_cnt_q <= 4'd0;
            rsp_q        <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_q        <= rsp_d;
        end
    end

    // Read data is gated to zero on the side that did not issue the read.
    assign ext_rvalid_o = (rsp_q == OWN_EXT);
    assign ext_rdata_o  = (rsp_q == OWN_EXT)  ? mem_rdata_i : 32'd0;
    assign core_rdata_o = (rsp_q == OWN_CORE) ? mem_rdata_i : 32'd0;

endmodule

// File: doc/triumph_dmem_arbiter.md
TRIUMPH_DMEM_ARBITER -- requirements
Module: triumph_dmem_arbiter

Interface
REQ-001 Parameter MAX_EXT_WAIT, default 4, the number of consecutive cycles an external request may be denied before it is forced through; legal range 1..15.
REQ-002 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-003 rstn_i  input  1  reset; asynchronous and active-low.
REQ-004 core_req_i  input  1  core load/store request this cycle.
REQ-005 core_we_i  input  1  core write enable (1 = store, 0 = load).
REQ-006 core_addr_i  input  32  core byte address.
REQ-007 core_wdata_i  input  32  core store data.
REQ-008 core_rdata_o  output  32  load data returned to the core.
REQ-009 core_stall_o  output  1  core request not served this cycle; the core holds its request.
REQ-010 ext_req_i  input  1  external requester (loader/debug) request.
REQ-011 ext_we_i  input  1  external write enable.
REQ-012 ext_addr_i  input  32  external byte address.
REQ-013 ext_wdata_i  input  32  external write data.
REQ-014 ext_gnt_o  output  1  external request accepted this cycle.
REQ-015 ext_rvalid_o  output  1  ext_rdata_o valid (external read response).
REQ-016 ext_rdata_o  output  32  external read data.
REQ-017 mem_addr_o  output  32  address to the single-port data memory.
REQ-018 mem_we_o  output  1  memory write enable.
REQ-019 mem_wdata_o  output  32  memory write data.
REQ-020 mem_rdata_i  input  32  memory read data, valid the cycle after the address (synchronous read).

Function
REQ-021 Each cycle selects at most one owner, combinationally: EXT if ext_req_i and (core_req_i = 0 or starve_cnt = MAX_EXT_WAIT); otherwise CORE if core_req_i; otherwise NONE.
REQ-022 Owner CORE: mem_addr_o/mem_wdata_o = core inputs, mem_we_o = core_we_i.
REQ-023 Owner EXT: mem_addr_o/mem_wdata_o = ext inputs, mem_we_o = ext_we_i, ext_gnt_o = 1.
REQ-024 Owner NONE: mem_addr_o = 0, mem_wdata_o = 0, mem_we_o = 0, ext_gnt_o = 0.
REQ-025 core_stall_o = core_req_i and owner = EXT; otherwise 0.
REQ-026 starve_cnt is a 4-bit counter: +1 on a cycle where ext_req_i = 1 and owner = CORE; cleared on a cycle where owner = EXT or ext_req_i = 0; it never exceeds MAX_EXT_WAIT.
REQ-027 Response tracker rsp_q (NONE/CORE/EXT) registers the owner of each read (we = 0) access; writes and idle cycles load NONE.
REQ-028 ext_rvalid_o = (rsp_q = EXT), exactly one cycle after the granted external read.
REQ-029 ext_rdata_o = mem_rdata_i when ext_rvalid_o = 1, else 0.
REQ-030 core_rdata_o = mem_rdata_i when rsp_q = CORE, else 0.
REQ-031 Simultaneous requests follow REQ-021 only; the EXT grant is a single cycle, and after it core regains priority because starve_cnt is 0.
REQ-032 An external requester dropping ext_req_i without a grant clears starve_cnt; no grant is remembered.
REQ-033 Back-to-back external reads are allowed; each grant produces exactly one ext_rvalid_o pulse, in order.

Reset
REQ-034 While rstn_i = 0: starve_cnt = 0, rsp_q = NONE, so ext_rvalid_o = 0, ext_rdata_o = 0 and core_rdata_o = 0, regardless of clk_i.
REQ-035 Combinational outputs follow REQ-021..025 from the inputs during reset.
REQ-036 Reset asserted mid-operation discards any pending read response; no ext_rvalid_o follows reset release.

Verification
REQ-037 Core-only load to 0x10, memory returns 0xDEADBEEF -> no stall, mem_addr_o = 0x10, next cycle core_rdata_o = 0xDEADBEEF, ext_rvalid_o = 0.
REQ-038 Ext-only write to 0x20 with data 0x55 -> same-cycle ext_gnt_o = 1, mem_we_o = 1, mem_wdata_o = 0x55; no rvalid.
REQ-039 Core and ext both request continuously, MAX_EXT_WAIT = 4 -> core owns 4 cycles, cycle 5 ext_gnt_o = 1 and core_stall_o = 1, then the pattern repeats with period 5.
REQ-040 Ext read at 0x30 granted; memory returns 0x1234 -> ext_rvalid_o = 1 with ext_rdata_o = 0x1234 exactly one cycle later, core_rdata_o = 0.
REQ-041 Ext request denied 2 cycles, then dropped for 1 cycle, then re-raised with core busy -> starve_cnt restarts from 0; grant comes on the 5th cycle after re-raise.
REQ-042 rstn_i pulsed low for one cycle right after an ext read grant -> ext_rvalid_o stays 0; arbitration resumes normally after release.
